// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: CPU port, DMA port and SRAM pins around the arbiter.
interface sram_bus_arbiter_if;
  logic        cpu_strobe;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [17:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic [17:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_drive;
  logic [7:0]  sram_din;
  logic        n_sram_cs;
  logic        n_sram_oe;
  logic        n_sram_we;
  modport slave (
    input  cpu_strobe, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, sram_din,
    output cpu_rdata, dma_rdata, dma_ack, sram_addr, sram_dout, sram_drive, n_sram_cs, n_sram_oe, n_sram_we
  );
  modport master (
    output cpu_strobe, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, sram_din,
    input  cpu_rdata, dma_rdata, dma_ack, sram_addr, sram_dout, sram_drive, n_sram_cs, n_sram_oe, n_sram_we
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one async SRAM between the CPU (priority) and a DMA master,
// sequencing CS/OE/WE strobes in clk100 cycles with a bounded DMA wait.
module sram_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int DMA_STARVE    = 4
) (
  input logic             clk100,
  input logic             n_reset,
  sram_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam int SW = $clog2(DMA_STARVE + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t      state_q;
  logic [1:0]  sync_q;
  logic        prev_q;
  logic        cpu_pend_q, cpu_pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [CW-1:0] cnt_q;
  logic        we_q, dma_q;
  logic [7:0]  rd_q;
  logic [17:0] addr_q;
  logic [7:0]  dout_q, cpu_rdata_q, dma_rdata_q;
  logic        drive_q, cs_n_q, oe_n_q, we_n_q, ack_q;
  logic        rise, starved, grant_dma, grant_cpu, grant_we;
  always_comb begin
    rise       = sync_q[1] & ~prev_q;
    starved    = starve_q == SW'(DMA_STARVE);
    grant_dma  = (state_q == IDLE) && bus.dma_req && (!cpu_pend_q || starved);
    grant_cpu  = (state_q == IDLE) && cpu_pend_q && !grant_dma;
    grant_we   = grant_dma ? bus.dma_we : bus.cpu_we;
    cpu_pend_d = (cpu_pend_q & ~grant_cpu) | rise;
    starve_d   = grant_dma ? '0 :
                 (grant_cpu && bus.dma_req && !starved) ? starve_q + SW'(1) : starve_q;
  end
  // cpu_strobe comes from the CPU clock domain; only its synchronised rising edge counts
  always_ff @(posedge clk100 or negedge n_reset)
    if (!n_reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      cpu_pend_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      sync_q     <= {sync_q[0], bus.cpu_strobe};
      prev_q     <= sync_q[1];
      cpu_pend_q <= cpu_pend_d;
      starve_q   <= starve_d;
    end
  always_ff @(posedge clk100 or negedge n_reset)
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      dma_q       <= 1'b0;
      rd_q        <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      drive_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE:
          if (grant_cpu || grant_dma) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            dma_q   <= grant_dma;
            we_q    <= grant_we;
            drive_q <= grant_we;
            addr_q  <= grant_dma ? bus.dma_addr : bus.cpu_addr;
            dout_q  <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          end
        SETUP: begin
          state_q <= STROBE;
          oe_n_q  <= we_q;
          we_n_q  <= ~we_q;
          cnt_q   <= CW'(ACCESS_CYCLES - 1);
        end
        STROBE:
          if (cnt_q == '0) begin
            state_q     <= HOLD;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ack_q       <= dma_q;
            rd_q        <= (!we_q && !dma_q) ? bus.sram_din : rd_q;
            dma_rdata_q <= (!we_q && dma_q) ? bus.sram_din : dma_rdata_q;
          end else
            cnt_q <= cnt_q - CW'(1);
        HOLD: begin
          state_q     <= IDLE;
          cs_n_q      <= 1'b1;
          drive_q     <= 1'b0;
          cpu_rdata_q <= (!we_q && !dma_q) ? rd_q : cpu_rdata_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_ack    = ack_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_dout  = dout_q;
  assign bus.sram_drive = drive_q;
  assign bus.n_sram_cs  = cs_n_q;
  assign bus.n_sram_oe  = oe_n_q;
  assign bus.n_sram_we  = we_n_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: SRAM model plus scoreboard-driven scenarios for the arbiter.
module tb_sram_bus_arbiter;
  localparam int AC = 2;
  localparam int ST = 4;
  logic clk100 = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk100 = ~clk100;
  sram_bus_arbiter_if bus();
  sram_bus_arbiter #(.ACCESS_CYCLES(AC), .DMA_STARVE(ST)) dut (
    .clk100(clk100), .n_reset(n_reset), .bus(bus.slave)
  );
  int total = 0;
  int bad = 0;
  logic [7:0] mem [0:262143];
  logic [7:0] cpu_exp_q[$];
  logic [7:0] dma_exp_q[$];
  logic       pre_en = 1'b0;
  logic [17:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  assign bus.sram_din = !bus.n_sram_oe ? mem[bus.sram_addr] : 8'h00;
  always @(posedge clk100)
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!bus.n_sram_cs && !bus.n_sram_we) mem[bus.sram_addr] <= bus.sram_dout;
  // bus monitor: per-access strobe counts, grant order and read-data scoreboard
  int done_cnt = 0, ack_cnt = 0, gap = 0;
  int oe_c, we_c, dr_c, last_oe, last_we, last_dr, last_gap;
  logic in_acc = 1'b0, saw_ack;
  logic [17:0] last_addr;
  logic [7:0] exp_b;
  logic grant_log[$];
  always @(negedge clk100) begin
    if (!n_reset) begin
      in_acc = 1'b0;
      gap = 0;
    end else begin
      total++;
      if (bus.sram_drive && !bus.n_sram_oe) begin
        bad++;
        $display("FAIL drive_oe_overlap drive=%b n_oe=%b required never both active", bus.sram_drive, bus.n_sram_oe);
      end
      if (bus.dma_ack) ack_cnt++;
      if (!bus.n_sram_cs) begin
        if (!in_acc) begin
          in_acc = 1'b1; oe_c = 0; we_c = 0; dr_c = 0; saw_ack = 1'b0;
          last_gap = gap; last_addr = bus.sram_addr;
        end
        if (!bus.n_sram_oe) oe_c++;
        if (!bus.n_sram_we) we_c++;
        if (bus.sram_drive) dr_c++;
        if (bus.dma_ack) begin
          saw_ack = 1'b1;
          if (oe_c > 0) begin
            total++;
            if (dma_exp_q.size() == 0) begin
              bad++;
              $display("FAIL dma_read_unexpected got=%h required no DMA read", bus.dma_rdata);
            end else begin
              exp_b = dma_exp_q.pop_front();
              if (bus.dma_rdata !== exp_b) begin
                bad++;
                $display("FAIL dma_rdata got=%h required=%h", bus.dma_rdata, exp_b);
              end
            end
          end
        end
      end else if (in_acc) begin
        in_acc = 1'b0;
        gap = 1;
        done_cnt++;
        last_oe = oe_c; last_we = we_c; last_dr = dr_c;
        grant_log.push_back(saw_ack);
        total++;
        if ((oe_c == 0) == (we_c == 0) || oe_c + we_c != AC) begin
          bad++;
          $display("FAIL strobe_len oe_cycles=%0d we_cycles=%0d required one of them=%0d", oe_c, we_c, AC);
        end
        if (oe_c > 0 && !saw_ack) begin
          total++;
          if (cpu_exp_q.size() == 0) begin
            bad++;
            $display("FAIL cpu_read_unexpected got=%h required no CPU read", bus.cpu_rdata);
          end else begin
            exp_b = cpu_exp_q.pop_front();
            if (bus.cpu_rdata !== exp_b) begin
              bad++;
              $display("FAIL cpu_rdata got=%h required=%h", bus.cpu_rdata, exp_b);
            end
          end
        end
      end else
        gap++;
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask
  task automatic preload(logic [17:0] a, logic [7:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    cyc(1);
    pre_en = 1'b0;
  endtask
  task automatic wait_done(int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 300) begin
      @(posedge clk100);
      k++;
    end
    #1;
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL access_timeout done=%0d required=%0d", done_cnt, target);
    end
  endtask
  task automatic wait_ack_then_drop();
    int k;
    k = 0;
    do begin
      @(negedge clk100);
      k++;
    end while (!bus.dma_ack && k < 300);
    total++;
    if (!bus.dma_ack) begin
      bad++;
      $display("FAIL ack_timeout dma_ack=%b required 1", bus.dma_ack);
    end
    @(posedge clk100);
    #1 bus.dma_req = 1'b0;
  endtask
  task automatic test_reset();
    n_reset = 1'b0;
    cyc(3);
    total += 4;
    if ({bus.n_sram_cs, bus.n_sram_oe, bus.n_sram_we} !== 3'b111) begin
      bad++; $display("FAIL reset_strobes got=%b required=111", {bus.n_sram_cs, bus.n_sram_oe, bus.n_sram_we});
    end
    if ({bus.sram_drive, bus.dma_ack} !== 2'b00) begin
      bad++; $display("FAIL reset_drive_ack got=%b required=00", {bus.sram_drive, bus.dma_ack});
    end
    if (bus.sram_addr !== 18'h0 || bus.sram_dout !== 8'h0) begin
      bad++; $display("FAIL reset_addr_dout got=%h/%h required=0/0", bus.sram_addr, bus.sram_dout);
    end
    if (bus.cpu_rdata !== 8'h0 || bus.dma_rdata !== 8'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h required=0/0", bus.cpu_rdata, bus.dma_rdata);
    end
    n_reset = 1'b1;
    cyc(2);
  endtask
  task automatic test_cpu_read();
    int n0;
    n0 = done_cnt;
    preload(18'h01234, 8'hA5);
    cpu_exp_q.push_back(8'hA5);
    bus.cpu_addr = 18'h01234; bus.cpu_we = 1'b0; bus.cpu_strobe = 1'b1;
    wait_done(n0 + 1);
    bus.cpu_strobe = 1'b0;
    total += 3;
    if (bus.cpu_rdata !== 8'hA5) begin
      bad++; $display("FAIL cpu_read_data got=%h required=a5", bus.cpu_rdata);
    end
    if (last_addr !== 18'h01234) begin
      bad++; $display("FAIL cpu_read_addr got=%h required=01234", last_addr);
    end
    if (last_oe !== AC || last_we !== 0 || last_dr !== 0) begin
      bad++; $display("FAIL cpu_read_strobes oe=%0d we=%0d drive=%0d required=%0d/0/0", last_oe, last_we, last_dr, AC);
    end
    cyc(3);
  endtask
  task automatic test_dma_write();
    int n0, a0, k;
    n0 = done_cnt; a0 = ack_cnt;
    bus.dma_we = 1'b1; bus.dma_addr = 18'h3FFFF; bus.dma_wdata = 8'h5A; bus.dma_req = 1'b1;
    k = 0;
    while (k < 50) begin
      @(posedge clk100);
      k++;
      @(negedge clk100);
      if (bus.dma_ack) break;
    end
    @(posedge clk100);
    #1 bus.dma_req = 1'b0;
    wait_done(n0 + 1);
    total += 5;
    if (k !== AC + 2) begin
      bad++; $display("FAIL dma_latency got=%0d required=%0d", k, AC + 2);
    end
    if (ack_cnt - a0 !== 1) begin
      bad++; $display("FAIL dma_ack_pulses got=%0d required=1", ack_cnt - a0);
    end
    if (last_we !== AC || last_oe !== 0 || last_dr !== AC + 2) begin
      bad++; $display("FAIL dma_write_strobes we=%0d oe=%0d drive=%0d required=%0d/0/%0d", last_we, last_oe, last_dr, AC, AC + 2);
    end
    if (last_addr !== 18'h3FFFF) begin
      bad++; $display("FAIL dma_write_addr got=%h required=3ffff", last_addr);
    end
    if (mem[18'h3FFFF] !== 8'h5A) begin
      bad++; $display("FAIL dma_write_mem got=%h required=5a", mem[18'h3FFFF]);
    end
    dma_exp_q.push_back(8'h5A);
    bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    wait_ack_then_drop();
    wait_done(n0 + 2);
    total++;
    if (bus.dma_rdata !== 8'h5A) begin
      bad++; $display("FAIL dma_readback got=%h required=5a", bus.dma_rdata);
    end
    cyc(3);
  endtask
  task automatic test_simultaneous();
    int n0;
    preload(18'h00010, 8'h3C);
    preload(18'h00020, 8'hC3);
    cpu_exp_q.push_back(8'h3C);
    dma_exp_q.push_back(8'hC3);
    n0 = done_cnt;
    grant_log.delete();
    bus.cpu_addr = 18'h00010; bus.cpu_we = 1'b0; bus.cpu_strobe = 1'b1;
    cyc(3);
    bus.dma_addr = 18'h00020; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    wait_ack_then_drop();
    wait_done(n0 + 2);
    bus.cpu_strobe = 1'b0;
    total += 3;
    if (grant_log.size() !== 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
      bad++; $display("FAIL both_order entries=%0d required cpu then dma", grant_log.size());
    end
    if (last_gap !== 1) begin
      bad++; $display("FAIL turnaround_gap got=%0d required=1", last_gap);
    end
    if (bus.cpu_rdata !== 8'h3C || bus.dma_rdata !== 8'hC3) begin
      bad++; $display("FAIL both_data got=%h/%h required=3c/c3", bus.cpu_rdata, bus.dma_rdata);
    end
    cyc(3);
  endtask
  task automatic test_starve();
    preload(18'h00030, 8'h77);
    for (int r = 0; r < 2; r++) begin
      logic stop;
      int first, k;
      stop = 1'b0;
      first = -1;
      dma_exp_q.push_back(8'h77);
      bus.cpu_we = 1'b1; bus.cpu_addr = 18'h00040; bus.cpu_wdata = 8'h11;
      bus.dma_we = 1'b0; bus.dma_addr = 18'h00030;
      fork
        begin
          while (!stop) begin
            bus.cpu_strobe = 1'b1;
            cyc(2);
            bus.cpu_strobe = 1'b0;
            cyc(2);
          end
        end
        begin
          k = 0;
          while (!in_acc && k < 100) begin
            cyc(1);
            k++;
          end
          grant_log.delete();
          bus.dma_req = 1'b1;
          wait_ack_then_drop();
          stop = 1'b1;
        end
      join
      cyc(15);
      foreach (grant_log[i]) if (grant_log[i] && first < 0) first = i;
      total++;
      if (first !== ST + 1) begin
        bad++; $display("FAIL starve_round%0d cpu_grants_before_dma got=%0d required=%0d", r, first - 1, ST);
      end
    end
  endtask
  task automatic test_held_strobe();
    int n0;
    preload(18'h00050, 8'h99);
    cpu_exp_q.push_back(8'h99);
    n0 = done_cnt;
    bus.cpu_addr = 18'h00050; bus.cpu_we = 1'b0; bus.cpu_strobe = 1'b1;
    cyc(50);
    bus.cpu_strobe = 1'b0;
    cyc(10);
    total += 2;
    if (done_cnt - n0 !== 1) begin
      bad++; $display("FAIL held_strobe_accesses got=%0d required=1", done_cnt - n0);
    end
    if (bus.cpu_rdata !== 8'h99) begin
      bad++; $display("FAIL held_strobe_data got=%h required=99", bus.cpu_rdata);
    end
  endtask
  task automatic test_reset_abort();
    int a0, k, n0;
    a0 = ack_cnt;
    bus.dma_we = 1'b1; bus.dma_addr = 18'h00060; bus.dma_wdata = 8'hEE; bus.dma_req = 1'b1;
    k = 0;
    do begin
      @(negedge clk100);
      k++;
    end while (bus.n_sram_we && k < 50);
    total++;
    if (bus.n_sram_we !== 1'b0) begin
      bad++; $display("FAIL abort_no_strobe n_we=%b required=0", bus.n_sram_we);
    end
    #2 n_reset = 1'b0;
    #1;
    total++;
    if ({bus.n_sram_cs, bus.n_sram_we, bus.n_sram_oe, bus.sram_drive, bus.dma_ack} !== 5'b11100) begin
      bad++; $display("FAIL abort_async got=%b required=11100", {bus.n_sram_cs, bus.n_sram_we, bus.n_sram_oe, bus.sram_drive, bus.dma_ack});
    end
    bus.dma_req = 1'b0;
    cyc(3);
    n_reset = 1'b1;
    cyc(5);
    total += 2;
    if (ack_cnt !== a0) begin
      bad++; $display("FAIL abort_ack got=%0d required=%0d", ack_cnt - a0, 0);
    end
    if (bus.n_sram_cs !== 1'b1 || bus.cpu_rdata !== 8'h00) begin
      bad++; $display("FAIL abort_idle n_cs=%b cpu_rdata=%h required=1/00", bus.n_sram_cs, bus.cpu_rdata);
    end
    n0 = done_cnt;
    cpu_exp_q.push_back(8'hA5);
    bus.cpu_addr = 18'h01234; bus.cpu_we = 1'b0; bus.cpu_strobe = 1'b1;
    wait_done(n0 + 1);
    bus.cpu_strobe = 1'b0;
    total++;
    if (bus.cpu_rdata !== 8'hA5) begin
      bad++; $display("FAIL after_abort_read got=%h required=a5", bus.cpu_rdata);
    end
    cyc(3);
  endtask
  initial begin
    bus.cpu_strobe = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_starve();
    test_held_strobe();
    test_reset_abort();
    total++;
    if (cpu_exp_q.size() != 0 || dma_exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover cpu=%0d dma=%0d required=0/0", cpu_exp_q.size(), dma_exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
